// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP status sweeper.
package xadc_pkg;
  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;
  localparam int RES_W  = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQ,
    WAIT_RDY,
    CAPTURE,
    NEXT
  } state_t;

  // Entry i is the DRP address of channel i: temp, VCCINT, VCCAUX, VP/VN.
  localparam logic [3:0][DRP_AW-1:0] CH_ADDR = {7'h03, 7'h02, 7'h01, 7'h00};
endpackage

// File: rtl/xadc_period_timer.sv
// Free-running 0..PERIOD-1 counter; tick is high in the last count of each period.
module xadc_period_timer #(
  parameter int PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/xadc_drp_sequencer.sv
// Periodic read-only DRP sweep of the XADC status channels.
// Define XADC_AVG_EN to average four back-to-back reads per channel.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PERIOD  = 100000,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  output logic [RES_W-1:0]  dato,
  output logic [1:0]        ch_sel,
  output logic              new_stb,
  output logic              busy,
  output logic              err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [TW-1:0]     tcnt;
  logic              tick, rd_ok, rd_tmo, last_rd;
  logic [RES_W-1:0]  sample, result;
  logic              unused_lsb;

  assign drp_dwe    = 1'b0;
  assign drp_di     = '0;
  assign sample     = drp_do[DRP_DW-1:DRP_DW-RES_W];
  assign unused_lsb = ^drp_do[DRP_DW-RES_W-1:0];

  xadc_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

`ifdef XADC_AVG_EN
  logic [1:0]       rd_cnt;
  logic [RES_W+1:0] acc, acc_sum;

  assign last_rd = (rd_cnt == 2'd3);
  assign acc_sum = acc + (RES_W+2)'(sample);
  assign result  = acc_sum[RES_W+1:2];

  // Accumulation only survives within one channel's REQ/WAIT_RDY loop.
  always_ff @(posedge clk) begin
    if (rst || !(state inside {REQ, WAIT_RDY})) begin
      acc    <= '0;
      rd_cnt <= '0;
    end else if (rd_ok) begin
      acc    <= acc_sum;
      rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  assign last_rd = 1'b1;
  assign result  = sample;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rd_ok     = 1'b0;
    rd_tmo    = 1'b0;
    case (state)
      IDLE:      if (en) state_nxt = WAIT_TICK;
      WAIT_TICK: if (tick) begin
        if (en) begin
          state_nxt = REQ;
          idx_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ:       state_nxt = WAIT_RDY;
      // A ready in the last allowed wait cycle still counts as a good read.
      WAIT_RDY: begin
        if (drp_drdy) begin
          rd_ok     = 1'b1;
          state_nxt = last_rd ? CAPTURE : REQ;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          rd_tmo    = 1'b1;
          state_nxt = NEXT;
        end
      end
      CAPTURE:   state_nxt = NEXT;
      NEXT: begin
        if (idx == 2'(N_CH - 1) || !en) begin
          state_nxt = WAIT_TICK;
        end else begin
          state_nxt = REQ;
          idx_nxt   = idx + 1'b1;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      drp_den   <= 1'b0;
      drp_daddr <= '0;
      dato      <= '0;
      ch_sel    <= '0;
      new_stb   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      tcnt    <= (state == WAIT_RDY) ? tcnt + 1'b1 : '0;
      drp_den <= (state_nxt == REQ);
      if (state_nxt == REQ) drp_daddr <= CH_ADDR[idx_nxt];
      busy    <= (state_nxt inside {REQ, WAIT_RDY, CAPTURE, NEXT});
      new_stb <= rd_ok && last_rd;
      if (rd_ok && last_rd) begin
        dato   <= result;
        ch_sel <= idx;
      end
      if (rd_tmo) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: reactive DRP model plus cycle-level expectations.
module tb_xadc_drp_sequencer;
  localparam int P  = 64;
  localparam int NC = 4;
  localparam int TO = 8;
`ifdef XADC_AVG_EN
  localparam int RD = 4;
`else
  localparam int RD = 1;
`endif

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        drp_den, drp_dwe, drp_drdy = 1'b0;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do = 16'h0;
  logic [11:0] dato;
  logic [1:0]  ch_sel;
  logic        new_stb, busy, err;

  xadc_drp_sequencer #(.N_CH(NC), .PERIOD(P), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .dato(dato), .ch_sel(ch_sel), .new_stb(new_stb), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic err_exp = 1'b0;
  int exp_den, sweep_start, end_cyc;
  logic [6:0]  addr_ref [4] = '{7'h00, 7'h01, 7'h02, 7'h03};
  int          sw_dl [4];
  logic [15:0] sw_dt [4];

  typedef struct {
    int          dly;
    logic [15:0] din;
    logic [11:0] exp_dato;
    logic        exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_den(input string nm);
    int n = 0;
    while (drp_den !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (drp_den !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no drp_den within 1000 cycles", nm);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    chk({nm, " den cycle"}, cyc, exp_den);
  endtask

  // One channel: RD reads answered d cycles after drp_den (d==0: never answered).
  task automatic do_channel(input int ch, input int d, input logic [15:0] data,
                            input logic [15:0] step, input bit drop);
    logic [13:0] sum;
    logic [15:0] dv;
    int t;
    sum = '0;
    for (int j = 0; j < RD; j++) begin
      wait_den($sformatf("ch%0d rd%0d", ch, j));
      t = cyc;
      if (ch == 0 && j == 0) sweep_start = t;
      chk("daddr", drp_daddr, addr_ref[ch]);
      chk("busy in sweep", busy, 1);
      if (drop && j == 0) en = 1'b0;
      dv = data + 16'(j) * step;
      if (d == 0) begin
        repeat (TO + 1) @(negedge clk);
        err_exp = 1'b1;
        chk("err on timeout", err, err_exp);
        chk("no new on timeout", new_stb, 0);
        end_cyc = t + TO + 1;
        exp_den = t + TO + 2;
        return;
      end
      repeat (d) @(negedge clk);
      chk("den one cycle", drp_den, 0);
      drp_drdy = 1'b1;
      drp_do   = dv;
      @(negedge clk);
      drp_drdy = 1'b0;
      drp_do   = 16'($urandom);
      sum = sum + 14'(dv[15:4]);
      if (j < RD - 1) begin
        exp_den = t + d + 1;
      end else begin
        chk("new", new_stb, 1);
        chk("dato", dato, 12'(sum >> $clog2(RD)));
        chk("ch_sel", ch_sel, ch);
        chk("err", err, err_exp);
        end_cyc = t + d + 2;
        exp_den = t + d + 3;
      end
    end
  endtask

  // Sweep ends at NEXT; the next one starts at the first tick seen in WAIT_TICK.
  task automatic finish_sweep();
    int m;
    while (cyc < end_cyc + 1) @(negedge clk);
    chk("busy end", busy, 0);
    m = 1;
    while (sweep_start + m * P - 1 < end_cyc + 1) m++;
    exp_den = sweep_start + m * P;
  endtask

  task automatic run_sweep(input logic [15:0] step, input int drop_ch);
    for (int c = 0; c < NC; c++) begin
      do_channel(c, sw_dl[c], sw_dt[c], step, c == drop_ch);
      if (!en) break;
    end
    finish_sweep();
  endtask

  task automatic set_nominal();
    for (int c = 0; c < NC; c++) begin
      sw_dl[c] = 2;
      sw_dt[c] = 16'hABC0;
    end
  endtask

  initial begin
    int c;
    bit den_seen;
    tbl[0] = '{2, 16'hABC0, 12'hABC, 1'b0};
    tbl[1] = '{1, 16'hFFFF, 12'hFFF, 1'b0};
    tbl[2] = '{3, 16'h000F, 12'h000, 1'b0};
    tbl[3] = '{TO, 16'h1234, 12'h123, 1'b0};
    tbl[4] = '{5, 16'h8001, 12'h800, 1'b0};
    tbl[5] = '{0, 16'h5555, 12'h800, 1'b1};
    tbl[6] = '{4, 16'h7FF0, 12'h7FF, 1'b1};
    tbl[7] = '{1, 16'h0010, 12'h001, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst den", drp_den, 0);
    chk("rst daddr", drp_daddr, 0);
    chk("rst dato", dato, 0);
    chk("rst ch_sel", ch_sel, 0);
    chk("rst new", new_stb, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("dwe tie", drp_dwe, 0);
    chk("di tie", drp_di, 0);

    rst = 1'b0;
    en  = 1'b1;
    exp_den = cyc + P + 1;

    // Nominal sweeps, second one exactly one period after the first.
    set_nominal();
    run_sweep(16'h0, -1);
    run_sweep(16'h0, -1);

    // Table vectors: truncation, ready in the timeout cycle, no-answer on ch 1.
    for (int i = 0; i < 8; i++) begin
      do_channel(i % 4, tbl[i].dly, tbl[i].din, 16'h0, 1'b0);
      chk($sformatf("tbl%0d dato", i), dato, tbl[i].exp_dato);
      chk($sformatf("tbl%0d err", i), err, tbl[i].exp_err);
      if (i % 4 == 3) finish_sweep();
    end

    // en dropped during the ch 1 read: ch 1 completes, no ch 2, IDLE at next tick.
    set_nominal();
    run_sweep(16'h0, 1);
    den_seen = 1'b0;
    while (cyc < exp_den - 1 + 10) begin
      @(negedge clk);
      if (drp_den === 1'b1) den_seen = 1'b1;
    end
    chk("no req after en drop", den_seen, 0);
    en = 1'b1;
    exp_den = cyc + P + 1;
    run_sweep(16'h0, -1);

    // Reset one cycle after drp_den, ready returned afterwards.
    wait_den("rst seq");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drp_drdy = 1'b1;
    drp_do = 16'hFFF0;
    c = cyc;
    chk("mid-rst den", drp_den, 0);
    chk("mid-rst daddr", drp_daddr, 0);
    chk("mid-rst dato", dato, 0);
    chk("mid-rst ch_sel", ch_sel, 0);
    chk("mid-rst new", new_stb, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst err", err, 0);
    @(negedge clk);
    drp_drdy = 1'b0;
    chk("late drdy no new", new_stb, 0);
    @(negedge clk);
    chk("late drdy no new 2", new_stb, 0);
    err_exp = 1'b0;
    exp_den = c + P + 1;
    run_sweep(16'h0, -1);

`ifdef XADC_AVG_EN
    for (int k = 0; k < NC; k++) begin
      sw_dl[k] = 1;
      sw_dt[k] = 16'h0010;
    end
    run_sweep(16'h0010, -1);
    chk("avg dato", dato, 12'h002);
`endif

    // Randomized sweeps against the cycle-level model.
    for (int s = 0; s < 25; s++) begin
      for (int k = 0; k < NC; k++) begin
        sw_dl[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
        sw_dt[k] = 16'($urandom);
      end
      run_sweep((RD > 1) ? 16'($urandom) : 16'h0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
